// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;
  localparam int MULDIV_CNT_W = 5;

  // Magnitude of a 32-bit operand when it is to be treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] opa_next,
  output logic [WIDTH-1:0]   opb_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Divide: acc[WIDTH:0] is the partial remainder, opa low half the divisor,
  // opb the dividend shifting out MSB-first while quotient bits shift in.
  // Multiply: acc accumulates, opa is the left-shifting multiplicand, opb the multiplier.
  always_comb begin
    shifted_s = {acc[WIDTH-1:0], opb[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, opa[WIDTH-1:0]};
    acc_next  = acc;
    opa_next  = opa;
    opb_next  = opb;
    if (is_div) begin
      if (!diff_s[WIDTH]) begin
        acc_next = {{(WIDTH-1){1'b0}}, diff_s};
        opb_next = {opb[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {{(WIDTH-1){1'b0}}, shifted_s};
        opb_next = {opb[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (opb[0]) begin
        acc_next = acc + opa;
      end else begin
        acc_next = acc;
      end
      opa_next = {opa[2*WIDTH-2:0], 1'b0};
      opb_next = {1'b0, opb[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MULDIV_CNT_W-1:0] LAST_CNT = MULDIV_CNT_W'(MULDIV_ITERS - 1);

  muldiv_state_t             state_r, state_nx;
  logic [MULDIV_CNT_W-1:0]   cnt_r, cnt_nx;
  logic [2*WIDTH-1:0]        acc_r, acc_nx, opa_r, opa_nx;
  logic [WIDTH-1:0]          opb_r, opb_nx;
  logic                      is_div_r, is_div_nx;
  logic                      neg_main_r, neg_main_nx;
  logic                      neg_rem_r, neg_rem_nx;
  logic [WIDTH-1:0]          hi_r, hi_nx, lo_r, lo_nx;
  logic                      busy_r, busy_nx, done_r, done_nx;

  logic [2*WIDTH-1:0]        core_acc_s, core_opa_s;
  logic [WIDTH-1:0]          core_opb_s;
  muldiv_op_t                op_s;
  logic                      signed_op_s;
  logic [WIDTH-1:0]          mag_rs_s, mag_rt_s;
  logic [2*WIDTH-1:0]        prod_fix_s;

  assign op_s        = muldiv_op_t'(op);
  assign signed_op_s = (op_s == OP_MULT) || (op_s == OP_DIV);
  assign mag_rs_s    = mag32(rs, signed_op_s);
  assign mag_rt_s    = mag32(rt, signed_op_s);
  assign prod_fix_s  = neg_main_r ? ((2*WIDTH)'(0) - core_acc_s) : core_acc_s;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .opa      (opa_r),
    .opb      (opb_r),
    .acc_next (core_acc_s),
    .opa_next (core_opa_s),
    .opb_next (core_opb_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    acc_nx      = acc_r;
    opa_nx      = opa_r;
    opb_nx      = opb_r;
    is_div_nx   = is_div_r;
    neg_main_nx = neg_main_r;
    neg_rem_nx  = neg_rem_r;
    hi_nx       = hi_r;
    lo_nx       = lo_r;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              state_nx    = ST_RUN;
              cnt_nx      = '0;
              busy_nx     = 1'b1;
              is_div_nx   = 1'b0;
              acc_nx      = '0;
              opa_nx      = {{WIDTH{1'b0}}, mag_rs_s};
              opb_nx      = mag_rt_s;
              neg_main_nx = signed_op_s && (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_rem_nx  = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_nx    = ST_RUN;
              cnt_nx      = '0;
              busy_nx     = 1'b1;
              is_div_nx   = 1'b1;
              acc_nx      = '0;
              opa_nx      = {{WIDTH{1'b0}}, mag_rt_s};
              opb_nx      = mag_rs_s;
              // A zero divisor must leave the all-ones quotient un-negated.
              neg_main_nx = signed_op_s && (rs[WIDTH-1] ^ rt[WIDTH-1]) && (rt != '0);
              neg_rem_nx  = signed_op_s && rs[WIDTH-1];
            end
            OP_MTHI: hi_nx = rs;
            OP_MTLO: lo_nx = rs;
            default: state_nx = ST_IDLE;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_nx  = core_acc_s;
        opa_nx  = core_opa_s;
        opb_nx  = core_opb_s;
        cnt_nx  = cnt_r + MULDIV_CNT_W'(1);
        busy_nx = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_nx = ST_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          if (is_div_r) begin
            lo_nx = neg_main_r ? (WIDTH'(0) - core_opb_s) : core_opb_s;
            hi_nx = neg_rem_r ? (WIDTH'(0) - core_acc_s[WIDTH-1:0]) : core_acc_s[WIDTH-1:0];
          end else begin
            hi_nx = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_nx = prod_fix_s[WIDTH-1:0];
          end
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath, HI/LO and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= '0;
      acc_r      <= '0;
      opa_r      <= '0;
      opb_r      <= '0;
      is_div_r   <= 1'b0;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_nx;
      acc_r      <= acc_nx;
      opa_r      <= opa_nx;
      opb_r      <= opb_nx;
      is_div_r   <= is_div_nx;
      neg_main_r <= neg_main_nx;
      neg_rem_r  <= neg_rem_nx;
      hi_r       <= hi_nx;
      lo_r       <= lo_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random vs model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    r = 64'd0;
    case (o)
      3'b000: begin p = longint'(sa) * longint'(sb); r = p; end
      3'b001: r = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'b011: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit inject);
    int nbusy;
    bit moved;
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    moved = 1'b0;
    while (busy && nbusy < 40) begin
      if (hi !== hi0 || lo !== lo0) moved = 1'b1;
      nbusy++;
      if (inject && nbusy == 5) begin
        start = 1'b1; op = 3'b001; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({name, " busy_cycles"}, 64'(nbusy), 64'd32);
    check({name, " hold"}, 64'(moved), 64'd0);
    check({name, " done_pulse"}, 64'(done), 64'd1);
    check({name, " hilo"}, {hi, lo}, exp);
    if (inject) begin
      start = 1'b1; op = 3'b011; rs = 32'd1; rt = 32'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " done_drop"}, 64'(done), 64'd0);
    check({name, " idle_busy"}, 64'(busy), 64'd0);
    if (inject) check({name, " hilo_kept"}, {hi, lo}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    int sel;

    vecs[0] = '{3'b001, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'b011, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[8] = '{3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    vecs[9] = '{3'b011, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};

    reset = 1'b1; start = 1'b0; op = 3'b000; rs = 32'd0; rt = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             {vecs[i].hi, vecs[i].lo}, 1'b0);
    end

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs = 32'h1234;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi lo_kept", 64'(lo), 64'h0FFF_FFFF);
    check("mthi no_busy", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    op = 3'b101; rs = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo hilo", {hi, lo}, {32'h1234, 32'h5678});

    // no-op code leaves everything untouched
    @(negedge clk);
    start = 1'b1; op = 3'b110; rs = 32'hDEAD_BEEF; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("noop hilo", {hi, lo}, {32'h1234, 32'h5678});
    check("noop busy", {62'd0, busy, done}, 64'd0);

    // start while busy and during DONE must be ignored
    run_op("ignore_start", 3'b001, 32'd3, 32'd5, 64'd15, 1'b1);

    // reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs = 32'hFFFF_FFFD; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_abort", 3'b000, 32'd6, 32'hFFFF_FFF9, {32'hFFFF_FFFF, 32'hFFFF_FFD6}, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 3) rb = -32'($urandom_range(1, 9));
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS-style datapath, sitting directly downstream of `regfile`. It consumes the two register read operands (`rd1`/`rd2`) and computes 32×32 products or 32/32 quotients and remainders over 32 cycles. Results go into architectural HI/LO registers, which the writeback path reads for `mfhi`/`mflo`. A start/busy/done handshake lets the controller stall dependent instructions.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: request to begin `op`; sampled on a rising edge only when `busy`=0.
- `op` in 3: operation code:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 11x: no-op
- `rs` in 32: first operand, from regfile `rd1`.
- `rt` in 32: second operand, from regfile `rd2`.
- `busy` out 1: iterative operation in progress.
- `done` out 1: one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States are IDLE, RUN and DONE. Reset puts the unit in IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0, and the iteration counter at 0.
- In IDLE, `start`=1 with a MULT, MULTU, DIV or DIVU code:
  - latch operand magnitudes: absolute values for signed ops, raw values for unsigned ops;
  - latch the result sign flags;
  - clear the counter and go to RUN.
- In IDLE, `start`=1 with MTHI or MTLO: write `rs` into `hi` or `lo` on that edge. Stay in IDLE; no `busy`, no `done`.
- In IDLE, `start`=1 with a no-op code: no state change.
- RUN performs one iteration per edge:
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle, 33-bit partial remainder.
- The counter increments from 0 to 31. The edge with counter=31 does the following:
  - writes the sign-corrected result into `hi`/`lo`;
  - moves to DONE.
- DONE lasts one cycle, then returns to IDLE unconditionally.
- Multiply results: `hi`=product[63:32], `lo`=product[31:0]. MULT negates the 64-bit product if the operand signs differ.
- Divide results: `lo`=quotient, `hi`=remainder.
  - DIV: quotient is negative when the operand signs differ; remainder takes the sign of `rs`; truncation toward zero.
- Divide by zero (`rt`=0), both DIV and DIVU: `lo`=32'hFFFF_FFFF, `hi`=`rs`. Full latency still applies.
- DIV with `rs`=32'h8000_0000 and `rt`=32'hFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0. This falls out of magnitude arithmetic with no special case.
- `start` while `busy`=1 or during DONE is ignored and not queued.
- `reset` asserted mid-operation aborts on that edge: state returns to IDLE and `hi`/`lo` go to 0.
- `hi`/`lo` hold their previous values for the whole of RUN.

## Timing
- Accepting edge E0 (IDLE with `start`=1): `busy`=1 from just after E0 through E32, i.e. 32 cycles.
- E1..E32 are the iterations. `hi`/`lo` take the new value at E32.
- After E32: `busy`=0 and `done`=1 for exactly one cycle. IDLE is re-entered at E33, and a new `start` can be accepted at E34.
- Total latency from accepting edge to results visible: 32 edges.
- MTHI/MTLO: the new value is visible one edge after the accepting edge. Back-to-back writes are allowed every cycle.
- `busy`, `done`, `hi` and `lo` are all registered outputs with no combinational paths from inputs.

## Structure
- Put in `muldiv_pkg`:
  - the `muldiv_op_t` enum covering the six op codes;
  - the `muldiv_state_t` enum (IDLE, RUN, DONE);
  - the constant `MULDIV_ITERS` = 32.
- Sub-module `muldiv_core`: per-cycle iteration datapath (accumulator / partial remainder step), combinational.
- `muldiv_unit` holds the FSM, counter, operand latches, sign fix-up and HI/LO registers.

## Test plan
- MULTU, `rs`=32'hFFFF_FFFF, `rt`=2 → after 32 busy cycles, `done` pulse; `hi`=1, `lo`=32'hFFFF_FFFE.
- MULT, `rs`=-3, `rt`=7 → `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFEB (-21).
- DIV, `rs`=-7, `rt`=2 → `lo`=32'hFFFF_FFFD (-3), `hi`=32'hFFFF_FFFF (-1).
- DIVU, `rs`=100, `rt`=0 → `lo`=32'hFFFF_FFFF, `hi`=100, same latency.
- MTHI 32'h1234 then MTLO 32'h5678 on consecutive cycles → `hi`/`lo` updated one edge later each. Then issue `start` MULTU while busy → that start is ignored and the original result is unchanged.
- MULT started, `reset` pulsed at iteration 10 → `busy`=0, `done`=0, `hi`=`lo`=0 next cycle. A new start is accepted afterwards and completes correctly.
